// File: rtl/jtdsp16_pkg.sv
// jtdsp16_pkg
// Shared definitions for the program ROM arbiter: default bus widths,
// the arbiter state encoding and the handshake wait count.
package jtdsp16_pkg;

  localparam int AW_DEF = 16;  // default ROM address width
  localparam int DW_DEF = 16;  // default ROM data width

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // no request outstanding
    ST_RD_INS = 2'd1,  // instruction read outstanding
    ST_RD_TBL = 2'd2,  // table read outstanding
    ST_GAP    = 2'd3   // one cycle with rom_cs low after acceptance
  } arb_state_t;

  // rom_ok is ignored in the issue cycle and the one after it. The wait
  // counter saturates at this value, and only then is rom_ok honoured.
  localparam logic [1:0] WAIT_ACC = 2'd2;

endpackage

// File: rtl/jtdsp16_rom_arb_if.sv
// jtdsp16_rom_arb_if
// External program ROM port (SDRAM-style request/valid handshake).
//   rom_addr : ROM address, held stable while rom_cs is high
//   rom_cs   : chip select / request
//   rom_data : read data from the ROM
//   rom_ok   : read data valid
// master = arbiter side, slave = ROM / memory controller side.
interface jtdsp16_rom_arb_if
  import jtdsp16_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic [DW-1:0] rom_data;
  logic          rom_ok;

  modport master (output rom_addr, output rom_cs, input rom_data, input rom_ok);
  modport slave  (input rom_addr, input rom_cs, output rom_data, output rom_ok);
endinterface

// File: rtl/jtdsp16_rom_buf.sv
// jtdsp16_rom_buf
// One-entry instruction buffer: tag, data and valid bit plus hit compare.
//   clk, rst     : clock, asynchronous active-high reset
//   i_fill       : load the entry (instruction read accepted)
//   i_fill_addr  : tag to store (address that was read)
//   i_fill_data  : instruction word to store
//   i_fetch_addr : current fetch address to compare against the tag
//   o_hit        : entry valid and tag matches i_fetch_addr
//   o_data       : stored instruction word
module jtdsp16_rom_buf
  import jtdsp16_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int CACHE_EN = 1
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_fill,
  input  logic [AW-1:0] i_fill_addr,
  input  logic [DW-1:0] i_fill_data,
  input  logic [AW-1:0] i_fetch_addr,
  output logic          o_hit,
  output logic [DW-1:0] o_data
);

  logic [AW-1:0] r_tag;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          w_drop;

  generate
    if (CACHE_EN != 0) begin : g_cache
      assign w_drop = 1'b0;
    end else begin : g_nocache
      // Without the cache, any movement of fetch_addr invalidates the
      // entry so the next fetch always goes to the ROM; a steady address
      // keeps being served from the registered word.
      logic [AW-1:0] r_last_addr;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_last_addr <= '0;
        else     r_last_addr <= i_fetch_addr;
      end
      assign w_drop = (i_fetch_addr != r_last_addr);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_tag   <= i_fill_addr;
      r_data  <= i_fill_data;
      r_valid <= 1'b1;
    end else if (w_drop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_hit  = r_valid && (r_tag == i_fetch_addr);
  assign o_data = r_data;

endmodule

// File: rtl/jtdsp16_rom_arb.sv
// jtdsp16_rom_arb
// Arbitrates the single program ROM port between instruction fetch and
// table reads, runs the variable-latency ROM handshake and drives stall.
//   clk, rst     : clock, asynchronous active-high reset
//   i_cen        : core clock enable (table request latch / tbl_ok consume)
//   i_fetch_addr : instruction address        o_ins_data/o_ins_ok : result
//   i_tbl_req    : table read request (on cen) i_tbl_addr : table address
//   o_tbl_data   : table read result          o_tbl_ok : result valid
//   o_stall      : core must hold its state
//   rom          : ROM port (master side)
module jtdsp16_rom_arb
  import jtdsp16_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int CACHE_EN = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cen,
  input  logic [AW-1:0]     i_fetch_addr,
  output logic [DW-1:0]     o_ins_data,
  output logic              o_ins_ok,
  input  logic              i_tbl_req,
  input  logic [AW-1:0]     i_tbl_addr,
  output logic [DW-1:0]     o_tbl_data,
  output logic              o_tbl_ok,
  output logic              o_stall,
  jtdsp16_rom_arb_if.master rom
);

  arb_state_t    r_state, w_state_next;
  logic          r_rom_cs;
  logic [AW-1:0] r_rom_addr;
  logic [1:0]    r_wait;

  logic          r_tbl_pend;   // table read requested, not yet consumed
  logic          r_tbl_done;   // table data captured, waiting for cen
  logic [AW-1:0] r_tbl_addr;
  logic [DW-1:0] r_tbl_data;

  logic          w_hit;
  logic [DW-1:0] w_buf_data;
  logic          w_tbl_new, w_tbl_want;
  logic [AW-1:0] w_tbl_addr;
  logic          w_busy, w_accept, w_fill;
  logic          w_issue_tbl, w_issue_ins;

  // A request arriving on this cen cycle is visible to the issue logic
  // straight away, so it still beats a simultaneous fetch miss.
  assign w_tbl_new  = i_cen && i_tbl_req && !r_tbl_pend;
  assign w_tbl_want = (r_tbl_pend && !r_tbl_done) || w_tbl_new;
  assign w_tbl_addr = r_tbl_pend ? r_tbl_addr : i_tbl_addr;

  assign w_busy   = (r_state == ST_RD_INS) || (r_state == ST_RD_TBL);
  assign w_accept = w_busy && (r_wait == WAIT_ACC) && rom.rom_ok;
  assign w_fill   = w_accept && (r_state == ST_RD_INS);

  jtdsp16_rom_buf #(
    .AW       (AW),
    .DW       (DW),
    .CACHE_EN (CACHE_EN)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .i_fill       (w_fill),
    .i_fill_addr  (r_rom_addr),
    .i_fill_data  (rom.rom_data),
    .i_fetch_addr (i_fetch_addr),
    .o_hit        (w_hit),
    .o_data       (w_buf_data)
  );

  // GAP makes the same issue decision as IDLE: its cycle is the single
  // rom_cs-low cycle, so a waiting request goes out right after it and
  // rom_cs is never low for more than one cycle between transfers.
  always_comb begin
    w_state_next = r_state;
    w_issue_tbl  = 1'b0;
    w_issue_ins  = 1'b0;
    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (w_tbl_want) begin
          w_state_next = ST_RD_TBL;
          w_issue_tbl  = 1'b1;
        end else if (!w_hit) begin
          w_state_next = ST_RD_INS;
          w_issue_ins  = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RD_INS, ST_RD_TBL: begin
        if (w_accept) w_state_next = ST_GAP;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rom_cs   <= 1'b0;
      r_rom_addr <= '0;
      r_wait     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_issue_tbl || w_issue_ins) begin
        r_rom_cs   <= 1'b1;
        r_rom_addr <= w_issue_tbl ? w_tbl_addr : i_fetch_addr;
        r_wait     <= '0;
      end else begin
        if (w_accept) r_rom_cs <= 1'b0;
        if (w_busy && (r_wait != WAIT_ACC)) r_wait <= r_wait + 2'd1;
      end
    end
  end

  // Table path: latch on cen, capture on acceptance, hand over on the
  // first cen after capture. A done flag only exists while pending, so
  // capture and hand-over can never target the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tbl_pend <= 1'b0;
      r_tbl_done <= 1'b0;
      r_tbl_addr <= '0;
      r_tbl_data <= '0;
    end else begin
      if (w_accept && (r_state == ST_RD_TBL)) begin
        r_tbl_data <= rom.rom_data;
        r_tbl_done <= 1'b1;
      end
      if (i_cen) begin
        if (r_tbl_pend && r_tbl_done) begin
          r_tbl_pend <= 1'b0;
          r_tbl_done <= 1'b0;
        end else if (!r_tbl_pend && i_tbl_req) begin
          r_tbl_pend <= 1'b1;
          r_tbl_addr <= i_tbl_addr;
        end
      end
    end
  end

  assign rom.rom_cs   = r_rom_cs;
  assign rom.rom_addr = r_rom_addr;

  assign o_ins_ok   = w_hit;
  assign o_ins_data = w_buf_data;
  assign o_tbl_ok   = r_tbl_pend && r_tbl_done;
  assign o_tbl_data = r_tbl_data;
  assign o_stall    = !w_hit || r_tbl_pend;

endmodule
